// File: rtl/zero_indices_collect.sv
// zero_indices_collect: gathers one job's zero-bit indices into a compacted buffer
// and presents a count/first/last/overflow summary on a valid/ready port.
module zero_indices_collect #(
   parameter int W     = 128,
   parameter int IDX_W = $clog2(W),
   parameter int DEPTH = W,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_start,
   input  logic             eng_busy_r,
   input  logic             eng_resp_valid,
   input  logic [IDX_W-1:0] eng_resp_index,
   output logic             collect_busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [IDX_W-1:0] out_first,
   output logic [IDX_W-1:0] out_last,
   output logic             out_overflow,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [IDX_W-1:0] rd_data,
   output logic             err_r
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] W_C = CNT_W'(W);
   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, PRESENT} state_t;
   state_t state;
   logic seen_busy;
   logic [1:0] drain;
   logic [IDX_W-1:0] mem [DEPTH];
   logic collecting, accept, wr_en;
   assign collecting   = state == COLLECT || state == DRAIN;
   assign accept       = collecting && eng_resp_valid;
   assign wr_en        = accept && out_count < DEPTH_C;
   assign collect_busy = state != IDLE;
   assign out_valid    = state == PRESENT;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         seen_busy    <= 1'b0;
         drain        <= '0;
         out_count    <= '0;
         out_first    <= '0;
         out_last     <= '0;
         out_overflow <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         if ((job_start && state != IDLE) || (eng_resp_valid && !collecting))
            err_r <= 1'b1;
         if (accept) begin
            if (out_count >= DEPTH_C) out_overflow <= 1'b1;
            if (out_count == '0) out_first <= eng_resp_index;
            else if (eng_resp_index <= out_last) err_r <= 1'b1;
            out_last <= eng_resp_index;
            if (out_count != W_C) out_count <= out_count + 1'b1;
         end
         case (state)
            IDLE: if (job_start) begin
               state        <= COLLECT;
               seen_busy    <= 1'b0;
               out_count    <= '0;
               out_first    <= '0;
               out_last     <= '0;
               out_overflow <= 1'b0;
            end
            // eng_busy_r rises a cycle after job_start, so only a fall after a seen rise ends the job
            COLLECT: begin
               if (eng_busy_r) seen_busy <= 1'b1;
               if (seen_busy && !eng_busy_r) begin
                  state <= DRAIN;
                  drain <= 2'd2;
               end
            end
            DRAIN: begin
               drain <= drain - 1'b1;
               if (drain == 2'd1) state <= PRESENT;
            end
            PRESENT: if (out_ready) state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk)
      if (wr_en) mem[out_count[AW-1:0]] <= eng_resp_index;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rd_data <= '0;
      else rd_data <= CNT_W'(rd_addr) < DEPTH_C ? mem[rd_addr[AW-1:0]] : '0;
endmodule

// File: tb/tb_zero_indices_collect.sv
// tb_zero_indices_collect: directed table of jobs on a full-depth and a 64-deep
// instance, plus hand-written latency, stall, error and reset sequences.
module tb_zero_indices_collect;
   logic clk = 1'b0, rst_n = 1'b0;
   logic job_start = 1'b0, eng_busy_r = 1'b0, eng_resp_valid = 1'b0, out_ready = 1'b0;
   logic [6:0] eng_resp_index = '0, rd_addr = '0;
   logic cb0, ov0, of0, er0, cb1, ov1, of1, er1;
   logic [7:0] cnt0, cnt1;
   logic [6:0] fi0, la0, rd0, fi1, la1, rd1;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   zero_indices_collect u0 (
      .clk(clk), .rst_n(rst_n), .job_start(job_start), .eng_busy_r(eng_busy_r),
      .eng_resp_valid(eng_resp_valid), .eng_resp_index(eng_resp_index),
      .collect_busy(cb0), .out_valid(ov0), .out_ready(out_ready), .out_count(cnt0),
      .out_first(fi0), .out_last(la0), .out_overflow(of0), .rd_addr(rd_addr),
      .rd_data(rd0), .err_r(er0));

   zero_indices_collect #(.DEPTH(64)) u1 (
      .clk(clk), .rst_n(rst_n), .job_start(job_start), .eng_busy_r(eng_busy_r),
      .eng_resp_valid(eng_resp_valid), .eng_resp_index(eng_resp_index),
      .collect_busy(cb1), .out_valid(ov1), .out_ready(out_ready), .out_count(cnt1),
      .out_first(fi1), .out_last(la1), .out_overflow(of1), .rd_addr(rd_addr),
      .rd_data(rd1), .err_r(er1));

   typedef struct {
      logic [127:0] vec;
      int cnt, first, last, ovf1;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string n, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s got %0d want %0d", n, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check_zero(input string t);
      chk({t, "_busy0"}, 32'(cb0), 0);  chk({t, "_valid0"}, 32'(ov0), 0);
      chk({t, "_cnt0"}, 32'(cnt0), 0);  chk({t, "_first0"}, 32'(fi0), 0);
      chk({t, "_last0"}, 32'(la0), 0);  chk({t, "_ovf0"}, 32'(of0), 0);
      chk({t, "_err0"}, 32'(er0), 0);   chk({t, "_rd0"}, 32'(rd0), 0);
      chk({t, "_busy1"}, 32'(cb1), 0);  chk({t, "_valid1"}, 32'(ov1), 0);
      chk({t, "_cnt1"}, 32'(cnt1), 0);  chk({t, "_err1"}, 32'(er1), 0);
   endtask

   task automatic reset_dut;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   // engine model: busy one cycle after start, responses lag busy by one cycle
   task automatic run_job(input logic [127:0] vec);
      int idx[$];
      for (int i = 0; i < 128; i++) if (!vec[i]) idx.push_back(i);
      job_start = 1'b1;
      tick;
      job_start = 1'b0;
      eng_busy_r = 1'b1;
      tick;
      if (idx.size() == 0) begin
         eng_busy_r = 1'b0;
         tick;
      end
      for (int k = 0; k < idx.size(); k++) begin
         eng_busy_r = k < idx.size() - 1;
         eng_resp_valid = 1'b1;
         eng_resp_index = 7'(idx[k]);
         tick;
      end
      eng_resp_valid = 1'b0;
      eng_busy_r = 1'b0;
   endtask

   task automatic wait_valid(input string n);
      int t = 0;
      while (!ov0 && t < 20) begin
         tick;
         t++;
      end
      chk({n, "_valid0"}, 32'(ov0), 1);
      chk({n, "_valid1"}, 32'(ov1), 1);
   endtask

   initial begin
      tbl[0] = '{vec: {{127{1'b1}}, 1'b0}, cnt: 1, first: 0, last: 0, ovf1: 0};
      tbl[1] = '{vec: {128{1'b1}}, cnt: 0, first: 0, last: 0, ovf1: 0};
      tbl[2] = '{vec: ~((128'd1 << 3) | (128'd1 << 10) | (128'd1 << 100)), cnt: 3, first: 3, last: 100, ovf1: 0};
      tbl[3] = '{vec: {{63{1'b1}}, {65{1'b0}}}, cnt: 65, first: 0, last: 64, ovf1: 1};
      tbl[4] = '{vec: {1'b0, {127{1'b1}}}, cnt: 1, first: 127, last: 127, ovf1: 0};
      tbl[5] = '{vec: {128{1'b0}}, cnt: 128, first: 0, last: 127, ovf1: 1};
      tick;
      tick;
      check_zero("rst");
      rst_n = 1'b1;
      tick;
      check_zero("post_rst");
      for (int j = 0; j < 6; j++) begin
         string n;
         n = $sformatf("job%0d", j);
         run_job(tbl[j].vec);
         wait_valid(n);
         chk({n, "_cnt0"}, 32'(cnt0), tbl[j].cnt);
         chk({n, "_first0"}, 32'(fi0), tbl[j].first);
         chk({n, "_last0"}, 32'(la0), tbl[j].last);
         chk({n, "_ovf0"}, 32'(of0), 0);
         chk({n, "_cnt1"}, 32'(cnt1), tbl[j].cnt);
         chk({n, "_first1"}, 32'(fi1), tbl[j].first);
         chk({n, "_last1"}, 32'(la1), tbl[j].last);
         chk({n, "_ovf1"}, 32'(of1), tbl[j].ovf1);
         chk({n, "_err0"}, 32'(er0), 0);
         out_ready = 1'b1;
         tick;
         out_ready = 1'b0;
         chk({n, "_drop_valid"}, 32'(ov0), 0);
         chk({n, "_idle"}, 32'(cb0), 0);
      end
      // buffer contents from the all-zero job
      rd_addr = 7'd5;   tick;
      chk("rd5_0", 32'(rd0), 5);    chk("rd5_1", 32'(rd1), 5);
      rd_addr = 7'd63;  tick;
      chk("rd63_0", 32'(rd0), 63);  chk("rd63_1", 32'(rd1), 63);
      rd_addr = 7'd64;  tick;
      chk("rd64_0", 32'(rd0), 64);  chk("rd64_1", 32'(rd1), 0);
      rd_addr = 7'd127; tick;
      chk("rd127_0", 32'(rd0), 127); chk("rd127_1", 32'(rd1), 0);
      // latency and a response in the final drain cycle
      job_start = 1'b1;
      tick;
      job_start = 1'b0;
      eng_busy_r = 1'b1;
      eng_resp_valid = 1'b1;
      eng_resp_index = 7'd10;
      tick;
      eng_busy_r = 1'b0;
      eng_resp_valid = 1'b0;
      tick;
      tick;
      chk("lat_early", 32'(ov0), 0);
      eng_resp_valid = 1'b1;
      eng_resp_index = 7'd20;
      tick;
      eng_resp_valid = 1'b0;
      chk("lat_valid", 32'(ov0), 1);
      chk("drain_cnt", 32'(cnt0), 2);
      chk("drain_first", 32'(fi0), 10);
      chk("drain_last", 32'(la0), 20);
      // stall in PRESENT
      for (int s = 0; s < 10; s++) begin
         tick;
         chk("stall_valid", 32'(ov0), 1);
         chk("stall_busy", 32'(cb0), 1);
         chk("stall_cnt", 32'(cnt0), 2);
         chk("stall_last", 32'(la0), 20);
      end
      chk("stall_err", 32'(er0), 0);
      job_start = 1'b1;
      tick;
      job_start = 1'b0;
      chk("start_present_err", 32'(er0), 1);
      chk("start_present_valid", 32'(ov0), 1);
      chk("start_present_cnt", 32'(cnt0), 2);
      job_start = 1'b1;
      out_ready = 1'b1;
      tick;
      job_start = 1'b0;
      out_ready = 1'b0;
      chk("hs_start_idle", 32'(cb0), 0);
      chk("hs_start_valid", 32'(ov0), 0);
      reset_dut;
      chk("err_cleared", 32'(er0), 0);
      // response while idle
      eng_resp_valid = 1'b1;
      eng_resp_index = 7'd9;
      tick;
      eng_resp_valid = 1'b0;
      chk("idle_resp_err", 32'(er0), 1);
      chk("idle_resp_cnt", 32'(cnt0), 0);
      reset_dut;
      // out-of-order indices, then asynchronous reset mid-collect
      rd_addr = 7'd0;
      job_start = 1'b1;
      tick;
      job_start = 1'b0;
      eng_busy_r = 1'b1;
      eng_resp_valid = 1'b1;
      eng_resp_index = 7'd5;
      tick;
      eng_resp_index = 7'd3;
      tick;
      eng_resp_valid = 1'b0;
      chk("order_err", 32'(er0), 1);
      chk("order_cnt", 32'(cnt0), 2);
      chk("order_first", 32'(fi0), 5);
      chk("order_last", 32'(la0), 3);
      chk("order_busy", 32'(cb0), 1);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      eng_busy_r = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      chk("after_rst_idle", 32'(cb0), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
